// File: rtl/param_reg_reader.sv
// param_reg_reader: bank of N registers with parameter-driven reset values,
// dumped in index order over a valid/ready stream after a start pulse.
// Ports: clk, rst (async, active-high); write port wr_en/wr_idx/wr_data;
//   start; stream out_valid/out_ready/out_data/out_idx/out_last;
//   status busy, err (sticky, cleared by reset only).
// Optional: define PARAM_REG_READER_PARITY_EN to add out_par (even parity
//   of out_data) and to drop odd-parity writes, which also sets err.
module param_reg_reader #(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int K    = 9001,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [W-1:0]         wr_data,
  input  logic                 start,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 err
`ifdef PARAM_REG_READER_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [W-1:0]   r_mem [N];
  logic [IW-1:0]  r_ptr;
  logic           r_valid;
  logic [W-1:0]   r_data;
  logic [IW-1:0]  r_idx;
  logic           r_busy;
  logic           r_err;
  logic           w_load;
  logic           w_hs;
  logic           w_ptr_last;
  logic           w_wr_ok;
  logic           w_wr_bad;

  assign w_ptr_last = (int'(r_ptr) == N - 1);

`ifdef PARAM_REG_READER_PARITY_EN
  logic r_par;
  assign w_wr_bad = wr_en & (^wr_data);
  assign out_par  = r_par;
`else
  assign w_wr_bad = 1'b0;
`endif

  // Out-of-range indices never reach the array.
  assign w_wr_ok = wr_en & (int'(wr_idx) < N) & ~w_wr_bad;

  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_hs      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_n = S_LOAD;
      end
      S_LOAD: begin
        w_load    = 1'b1;
        w_state_n = S_SEND;
      end
      S_SEND: begin
        if (r_valid && out_ready) begin
          w_hs      = 1'b1;
          w_state_n = w_ptr_last ? S_IDLE : S_LOAD;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= W'(K) + W'(i) * W'(STEP);
      end
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
`ifdef PARAM_REG_READER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      // Same-index write and LOAD: LOAD reads the pre-edge value.
      if (w_wr_ok) r_mem[wr_idx] <= wr_data;
      if ((start && r_busy) || w_wr_bad) r_err <= 1'b1;
      if (r_state == S_IDLE && start) begin
        r_busy <= 1'b1;
        r_ptr  <= '0;
      end
      if (w_load) begin
        r_data  <= r_mem[r_ptr];
        r_idx   <= r_ptr;
        r_valid <= 1'b1;
`ifdef PARAM_REG_READER_PARITY_EN
        r_par   <= ^r_mem[r_ptr];
`endif
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        if (w_ptr_last) r_busy <= 1'b0;
        else            r_ptr  <= r_ptr + 1'b1;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_valid & (int'(r_idx) == N - 1);
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
